flp_burst_tx: RTL
=================

# flp_burst_tx

Parametrised link-pulse transmitter for the Ethernet autonegotiation path: emits either 10BASE-T normal link pulses (NLP) or full FLP bursts carrying a run-time-loadable link code word (LCW) of configurable width. All timing (pulse width, slot spacing, burst period) is a parameter in clock cycles. It drives the TXp/TXm pulse pair directly and takes new LCWs from the autonegotiation controller through a valid/ready handshake at burst boundaries.

## Interface
- LCW_W, 16: LCW bits per burst; burst has 2*LCW_W+1 positions.
- PULSE_CYC, 2: pulse high time in cycles (≥1).
- SLOT_CYC, 1000: cycles between consecutive positions (> PULSE_CYC).
- BURST_CYC, 256000: cycles from one burst/NLP start to the next (> (2*LCW_W+1)*SLOT_CYC).
- LCW_INIT, 16'h01E1: LCW used after reset until a word is accepted.
- CLK  in  1  single clock; all logic on posedge.
- RSTn  in  1  reset, synchronous, active-low.
- EN  in  1  1 = transmit periodically; 0 = stop after the current burst.
- MODE  in  1  0 = NLP (single pulse per period), 1 = FLP burst; sampled at launch.
- LCW_DATA  in  LCW_W  next code word, bit 0 sent first.
- LCW_VALID  in  1  LCW_DATA valid.
- LCW_READY  out  1  high only in the launch cycle.
- BUSY  out  1  high from first pulse position through end of last slot.
- BURST_DONE  out  1  one-cycle strobe in last cycle of last slot.
- TXp  out  1  high during pulse.
- TXm  out  1  high when BUSY and not pulsing; 0 when idle (quiet line).

## Operation
- States: IDLE, SLOT (inside a burst), GAP (waiting out period).
- Launch cycle: IDLE with EN=1, or GAP at terminal count with EN=1. LCW_READY=1 in exactly that cycle. If LCW_VALID=1 then LCW_DATA is captured at that edge and used for this burst; otherwise the previously held word (LCW_INIT after reset) repeats.
- MODE latched at launch; changes mid-burst ignored.
- FLP: positions p = 0..2*LCW_W, each SLOT_CYC cycles. Even p: clock pulse, always sent. Odd p: data pulse sent iff LCW[(p-1)/2]=1; absent pulse leaves TXp=0.
- NLP: only position 0 pulses; burst is one slot long.
- After last slot: GAP until BURST_CYC cycles after launch edge, then relaunch if EN=1, else IDLE.
- EN=0 never truncates a burst; GAP with EN=0 at terminal count → IDLE.
- TXp and TXm never both 1.

## Timing
- Reset (RSTn=0 at an edge): state IDLE, counters 0, held LCW = LCW_INIT, all outputs 0 next cycle, including mid-pulse.
- Launch at edge N: first pulse TXp=1 in cycles N+1 … N+PULSE_CYC; BUSY=1 from N+1.
- Position p pulse starts at cycle N+1+p*SLOT_CYC.
- BURST_DONE and last BUSY cycle: N+(2*LCW_W+1)*SLOT_CYC (FLP) or N+SLOT_CYC (NLP).
- Next launch edge: N+BURST_CYC exactly (start-to-start period, independent of LCW content).
- Registered outputs, no combinational path from inputs to TXp/TXm; LCW_READY is a decode of state/counter only.
- Cycle counter width clog2(BURST_CYC); position counter width clog2(2*LCW_W+1).

## Structure
- Package flp_pkg: state enum, MODE_NLP/MODE_FLP constants, default LCW constant.
- Sub-module flp_slot_timer: free-running-per-slot cycle counter with pulse-end and slot-end strobes, parametrised by PULSE_CYC/SLOT_CYC; top holds FSM, position counter, LCW register, period counter.

## Test plan
Bench params: PULSE_CYC=2, SLOT_CYC=8, BURST_CYC=400, LCW_W=16.
- Reset, EN=1, MODE=1, VALID=0 → burst of LCW 16'h01E1: 22 pulses (17 clock + 5 data), data at p=1,11,13,15,17; BURST_DONE 264 cycles after launch.
- VALID=1 with 16'hFFFF at launch → 33 pulses, READY/VALID overlap one cycle; next burst with VALID=0 repeats 33 pulses.
- MODE=0 → one 2-cycle TXp pulse every 400 cycles, BUSY 8 cycles, no data pulses; MODE toggled mid-slot has no effect until next launch.
- EN dropped at position 10 → burst completes all 33 positions, BURST_DONE fires, then IDLE, TXp=TXm=0, no further launches.
- RSTn=0 during a pulse → TXp, TXm, BUSY = 0 next cycle; after release with EN=1, LCW_INIT sent.
- Continuous EN=1 over 5 bursts → launch spacing exactly 400 cycles, TXp&TXm never both 1.

Source files
------------

// File: rtl/flp_pkg.sv
// -----------------------------------------------------------------------------
// flp_pkg
// Shared definitions for the link-pulse transmitter slice:
//   flp_state_t  - transmitter FSM states (idle, inside a burst, waiting out
//                  the burst period)
//   MODE_NLP     - single normal link pulse per period
//   MODE_FLP     - full fast link pulse burst carrying a link code word
//   LCW_DEFAULT  - code word transmitted after reset until one is loaded
// -----------------------------------------------------------------------------
package flp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOT = 2'd1,
        ST_GAP  = 2'd2
    } flp_state_t;

    localparam logic MODE_NLP = 1'b0;
    localparam logic MODE_FLP = 1'b1;

    localparam logic [15:0] LCW_DEFAULT = 16'h01E1;

endpackage

// File: rtl/flp_slot_timer.sv
// -----------------------------------------------------------------------------
// flp_slot_timer
// Cycle counter that restarts at the beginning of every pulse position (slot)
// and flags the last cycle of the pulse and the last cycle of the slot.
//
// Ports:
//   CLK        in   clock, all logic on posedge
//   RSTn       in   synchronous active-low reset
//   start      in   restart the count (burst launch)
//   run        in   count while high (transmitter inside a burst)
//   pulse_end  out  last cycle of the pulse-high window of the current slot
//   slot_end   out  last cycle of the current slot
// -----------------------------------------------------------------------------
module flp_slot_timer #(
    parameter int PULSE_CYC = 2,
    parameter int SLOT_CYC  = 1000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic start,
    input  logic run,
    output logic pulse_end,
    output logic slot_end
);

    localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run) begin
            // Wraps at the slot boundary so the next position starts at 0
            // without any help from the FSM.
            if (cnt == SLOT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign pulse_end = run && (cnt == PULSE_LAST);
    assign slot_end  = run && (cnt == SLOT_LAST);

endmodule

// File: rtl/flp_burst_tx.sv
// -----------------------------------------------------------------------------
// flp_burst_tx
// Autonegotiation link-pulse transmitter. Emits either one normal link pulse
// (NLP) or a fast link pulse burst (FLP) of 2*LCW_W+1 positions every
// BURST_CYC cycles. Even positions carry clock pulses, odd positions carry the
// link code word, bit 0 first. A new code word is accepted only in the launch
// cycle; otherwise the held word repeats.
//
// Ports:
//   CLK         in   clock, all logic on posedge
//   RSTn        in   synchronous active-low reset
//   EN          in   1 = transmit periodically, 0 = stop after current burst
//   MODE        in   MODE_NLP / MODE_FLP, latched at launch
//   LCW_DATA    in   next link code word
//   LCW_VALID   in   LCW_DATA valid
//   LCW_READY   out  high only in the launch cycle
//   BUSY        out  high from first pulse position through end of last slot
//   BURST_DONE  out  strobe in the last cycle of the last slot
//   TXp         out  high during a pulse
//   TXm         out  high while busy and not pulsing
// -----------------------------------------------------------------------------
module flp_burst_tx
    import flp_pkg::*;
#(
    parameter int               LCW_W     = 16,
    parameter int               PULSE_CYC = 2,
    parameter int               SLOT_CYC  = 1000,
    parameter int               BURST_CYC = 256000,
    parameter logic [LCW_W-1:0] LCW_INIT  = LCW_W'(LCW_DEFAULT)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             EN,
    input  logic             MODE,
    input  logic [LCW_W-1:0] LCW_DATA,
    input  logic             LCW_VALID,
    output logic             LCW_READY,
    output logic             BUSY,
    output logic             BURST_DONE,
    output logic             TXp,
    output logic             TXm
);

    localparam int NPOS  = 2 * LCW_W + 1;
    localparam int POS_W = $clog2(NPOS);
    localparam int PER_W = $clog2(BURST_CYC);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * LCW_W);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(BURST_CYC - 1);

    flp_state_t       state;
    logic [POS_W-1:0] pos;
    logic [PER_W-1:0] per_cnt;
    logic [LCW_W-1:0] lcw_q;
    logic             mode_q;
    logic             txp_q;
    logic             txm_q;

    logic             launch;
    logic             last_pos;
    logic             next_pulse;
    logic             pulse_end;
    logic             slot_end;

    // per_cnt counts from 0 in the first cycle after the launch edge, so the
    // terminal count BURST_CYC-1 lands the relaunch exactly BURST_CYC edges
    // after the previous one, regardless of burst content.
    assign launch = RSTn && EN &&
                    ((state == ST_IDLE) || ((state == ST_GAP) && (per_cnt == PER_LAST)));

    assign last_pos = (mode_q == MODE_NLP) ? (pos == '0) : (pos == POS_LAST);

    // Pulse decision for position pos+1: after an odd position comes a clock
    // pulse; after an even position comes data bit pos/2.
    assign next_pulse = pos[0] ? 1'b1
                               : |(lcw_q & (LCW_W'(1) << (pos >> 1)));

    flp_slot_timer #(
        .PULSE_CYC (PULSE_CYC),
        .SLOT_CYC  (SLOT_CYC)
    ) u_slot_timer (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .start     (launch),
        .run       (state == ST_SLOT),
        .pulse_end (pulse_end),
        .slot_end  (slot_end)
    );

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register in this block sees pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state   <= ST_IDLE;
            pos     <= '0;
            per_cnt <= '0;
            // NOTE: lcw_q is a single register, not a memory array, so it
            // takes a reset value like any other flop.
            lcw_q   <= LCW_INIT;
            mode_q  <= MODE_NLP;
            txp_q   <= 1'b0;
            txm_q   <= 1'b0;
        end else if (launch) begin
            state   <= ST_SLOT;
            pos     <= '0;
            per_cnt <= '0;
            mode_q  <= MODE;
            if (LCW_VALID) begin
                lcw_q <= LCW_DATA;
            end
            // Position 0 is always a clock pulse in both modes.
            txp_q   <= 1'b1;
            txm_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    per_cnt <= '0;
                end
                ST_SLOT: begin
                    per_cnt <= per_cnt + PER_W'(1);
                    if (slot_end) begin
                        if (last_pos) begin
                            state <= ST_GAP;
                            txp_q <= 1'b0;
                            txm_q <= 1'b0;
                        end else begin
                            pos   <= pos + POS_W'(1);
                            txp_q <= next_pulse;
                            txm_q <= !next_pulse;
                        end
                    end else if (pulse_end) begin
                        txp_q <= 1'b0;
                        txm_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    // Reaching terminal count here means EN was low, since
                    // EN high would have taken the launch branch.
                    if (per_cnt == PER_LAST) begin
                        state   <= ST_IDLE;
                        per_cnt <= '0;
                    end else begin
                        per_cnt <= per_cnt + PER_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign LCW_READY  = launch;
    assign BUSY       = (state == ST_SLOT);
    assign BURST_DONE = (state == ST_SLOT) && slot_end && last_pos;
    assign TXp        = txp_q;
    assign TXm        = txm_q;

endmodule
